imm_decode_stage: RTL and testbench
===================================

Name: imm_decode_stage

Overview:
- Registered immediate-generation pipeline stage between fetch and execute.
- Classifies each instruction's format and produces an XLEN-wide sign-extended immediate plus an illegal-opcode flag.
- Covers all RV32I/RV64I base formats, including U-type (LUI/AUIPC) and R-type.
- Valid/ready handshakes on both sides; a 2-entry skid buffer gives full throughput under back-pressure. Flush input for branch redirect.

Parameters:
- XLEN, 32, datapath/immediate width; legal values 32 or 64.
- PC_W, 32, width of the PC carried alongside the instruction.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_instr  in  32  instruction word
- in_pc  in  PC_W  instruction PC
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts
- out_instr  out  32  instruction, passed through
- out_pc  out  PC_W  PC, passed through
- out_imm  out  XLEN  decoded immediate
- out_fmt  out  3  imm_fmt_e: R, I, S, B, U, J, NONE
- out_illegal  out  1  unknown opcode, or instr[1:0] != 2'b11

Behaviour:
- Clocking and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: out_valid=0, skid_valid=0, in_ready=1. out_imm, out_instr and out_pc are 0; out_fmt=NONE; out_illegal=0.
- Accept and issue: accept = in_valid & in_ready; issue = out_valid & out_ready. in_ready = !skid_valid (registered, no combinational path from out_ready).
- Latency: exactly 1 cycle from accept to out_valid when the output register is free.
- Output register load: when !out_valid | out_ready:
  - if skid_valid, load the skid entry and clear the skid;
  - else, if accept, load the decoded input;
  - else, clear out_valid.
- Stalled capture: when out_valid & !out_ready & accept, the decoded input goes into the skid register and skid_valid is set.
- Ordering: strictly in order; no entry is dropped or duplicated. Output fields hold stable while out_valid & !out_ready.
- Decode, performed combinationally on the input before registering. sext() means sign-extend to XLEN.
  - ITYPE 0010011, LOAD 0000011, JALR 1100111: I-format, sext(instr[31:20]).
  - STORE 0100011: S-format, sext({instr[31:25], instr[11:7]}).
  - BTYPE 1100011: B-format, sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - JAL 1101111: J-format, sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - LUI 0110111, AUIPC 0010111: U-format, sext({instr[31:12], 12'b0}). For XLEN=64, bits 63:32 copy instr[31].
  - RTYPE 0110011: R-format, imm=0.
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
- Illegal entries still flow through the handshake normally.
- Flush: next cycle out_valid=0 and skid_valid=0. flush dominates a simultaneous accept, and the accepted entry is discarded. flush together with reset behaves as reset.
- Reset mid-operation: all buffered entries lost; outputs return to reset values next cycle.

Optional Feature:
- Macro: IMM_DECODE_ZICSR_EN.
- Defined: SYSTEM opcode 1110011 decodes as fmt=CSR (encoding 3'd7), imm = zero-extended instr[19:15] (zimm), illegal=0.
- Undefined: SYSTEM decodes as NONE with illegal=1.

Decomposition:
- Shared package cpu_defs gains the imm_fmt_e enum (R=0, I=1, S=2, B=3, U=4, J=5, NONE=6, CSR=7).
- It also gains the constants OPCODE_LUI, OPCODE_AUIPC, OPCODE_RTYPE and OPCODE_SYSTEM, alongside the existing opcode constants.
- Sub-module imm_decode_comb (parameter XLEN): purely combinational instr -> {imm, fmt, illegal}. It is instantiated once, on the input side.
- imm_decode_stage holds only the handshake, output register and skid buffer.

Test Plan:
- addi 0xFFF00093, out_ready=1: one cycle later out_valid=1, imm=0xFFFFFFFF, fmt=I, illegal=0.
- sw 0xFE112E23 -> imm=0xFFFFFFFC, fmt=S. jal 0xFF9FF06F -> imm=0xFFFFFFF8, fmt=J.
- lui 0x123452B7, XLEN=32 -> 0x12345000. lui 0x800002B7, XLEN=64 -> 0xFFFFFFFF80000000, fmt=U.
- Back-pressure: out_ready=0, three back-to-back in_valid.
  - Two entries accepted; in_ready drops after the second.
  - Raise out_ready: all three emerge in order over consecutive cycles.
- Flush while both entries are full and in_valid=1: next cycle out_valid=0 and in_ready=1. A subsequent instruction issues normally.
- Opcode 0x0000007F -> illegal=1, imm=0, fmt=NONE. 0x00000013 with instr[1:0] forced to 01 -> illegal=1. reset asserted mid-stall -> reset values next cycle.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: base opcodes and the immediate-format encoding.
// Used by the imm_decode_stage slice (optional SYSTEM/CSR decode: IMM_DECODE_ZICSR_EN).
package cpu_defs;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6,
    FMT_CSR  = 3'd7
  } imm_fmt_e;

  localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_BTYPE  = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode_comb.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Defining IMM_DECODE_ZICSR_EN decodes SYSTEM as CSR with a zero-extended zimm.
module imm_decode_comb
  import cpu_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output imm_fmt_e        fmt_o,
  output logic            illegal_o
);

  logic signed [31:0] raw;
  logic [6:0]         opcode;

  assign opcode = instr_i[6:0];

  always_comb begin
    raw       = '0;
    fmt_o     = FMT_NONE;
    illegal_o = 1'b0;
    case (opcode)
      OPCODE_ITYPE, OPCODE_LOAD, OPCODE_JALR: begin
        fmt_o = FMT_I;
        raw   = {{20{instr_i[31]}}, instr_i[31:20]};
      end
      OPCODE_STORE: begin
        fmt_o = FMT_S;
        raw   = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      end
      OPCODE_BTYPE: begin
        fmt_o = FMT_B;
        raw   = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                 instr_i[11:8], 1'b0};
      end
      OPCODE_JAL: begin
        fmt_o = FMT_J;
        raw   = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                 instr_i[30:21], 1'b0};
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        fmt_o = FMT_U;
        raw   = {instr_i[31:12], 12'b0};
      end
      OPCODE_RTYPE: begin
        fmt_o = FMT_R;
      end
`ifdef IMM_DECODE_ZICSR_EN
      OPCODE_SYSTEM: begin
        fmt_o = FMT_CSR;
        raw   = {27'b0, instr_i[19:15]};
      end
`endif
      // opcode includes instr[1:0], so a bad compressed-space encoding lands here too
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  // signed size cast: bits above 31 replicate raw[31] on RV64
  assign imm_o = XLEN'(raw);

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage with valid/ready on both sides and a
// one-entry skid behind the output register. Optional macro: IMM_DECODE_ZICSR_EN.
module imm_decode_stage
  import cpu_defs::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr_i   (in_instr),
    .imm_o     (dec_imm),
    .fmt_o     (dec_fmt),
    .illegal_o (dec_illegal)
  );

  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [PC_W-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  imm_fmt_e        out_fmt_q, out_fmt_d;
  logic            out_illegal_q, out_illegal_d;

  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  imm_fmt_e        skid_fmt_q, skid_fmt_d;
  logic            skid_illegal_q, skid_illegal_d;

  logic accept;

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_instr_d    = out_instr_q;
    out_pc_d       = out_pc_q;
    out_imm_d      = out_imm_q;
    out_fmt_d      = out_fmt_q;
    out_illegal_d  = out_illegal_q;
    skid_valid_d   = skid_valid_q;
    skid_instr_d   = skid_instr_q;
    skid_pc_d      = skid_pc_q;
    skid_imm_d     = skid_imm_q;
    skid_fmt_d     = skid_fmt_q;
    skid_illegal_d = skid_illegal_q;

    if (out_valid_q && !out_ready && accept) begin
      skid_valid_d   = 1'b1;
      skid_instr_d   = in_instr;
      skid_pc_d      = in_pc;
      skid_imm_d     = dec_imm;
      skid_fmt_d     = dec_fmt;
      skid_illegal_d = dec_illegal;
    end

    // skid always drains first so ordering is preserved
    if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d   = 1'b1;
        out_instr_d   = skid_instr_q;
        out_pc_d      = skid_pc_q;
        out_imm_d     = skid_imm_q;
        out_fmt_d     = skid_fmt_q;
        out_illegal_d = skid_illegal_q;
        skid_valid_d  = 1'b0;
      end else if (accept) begin
        out_valid_d   = 1'b1;
        out_instr_d   = in_instr;
        out_pc_d      = in_pc;
        out_imm_d     = dec_imm;
        out_fmt_d     = dec_fmt;
        out_illegal_d = dec_illegal;
      end else begin
        out_valid_d   = 1'b0;
      end
    end

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q    <= 1'b0;
      out_instr_q    <= '0;
      out_pc_q       <= '0;
      out_imm_q      <= '0;
      out_fmt_q      <= FMT_NONE;
      out_illegal_q  <= 1'b0;
      skid_valid_q   <= 1'b0;
      skid_instr_q   <= '0;
      skid_pc_q      <= '0;
      skid_imm_q     <= '0;
      skid_fmt_q     <= FMT_NONE;
      skid_illegal_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_instr_q    <= out_instr_d;
      out_pc_q       <= out_pc_d;
      out_imm_q      <= out_imm_d;
      out_fmt_q      <= out_fmt_d;
      out_illegal_q  <= out_illegal_d;
      skid_valid_q   <= skid_valid_d;
      skid_instr_q   <= skid_instr_d;
      skid_pc_q      <= skid_pc_d;
      skid_imm_q     <= skid_imm_d;
      skid_fmt_q     <= skid_fmt_d;
      skid_illegal_q <= skid_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: an RV32 and an RV64 instance share stimulus.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_instr, out_pc, out_imm;
  logic [2:0]  out_fmt;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_instr64, out_pc64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal)
  );

  imm_decode_stage #(.XLEN(64), .PC_W(32)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid64), .out_ready(out_ready), .out_instr(out_instr64),
    .out_pc(out_pc64), .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // accept one instruction with out_ready high; result is visible on return
  task automatic issue1(input logic [31:0] instr, input logic [31:0] pc);
    in_instr  = instr;
    in_pc     = pc;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    $display("txn instr=%h pc=%h -> valid=%0b imm=%h fmt=%0d ill=%0b",
             instr, pc, out_valid, out_imm, out_fmt, out_illegal);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_imm", out_imm, 0);
    check("rst_instr", out_instr, 0);
    check("rst_fmt", out_fmt, 6);
    check("rst_illegal", out_illegal, 0);
    reset = 1'b0;
    step();

    issue1(32'hFFF00093, 32'h0000_1000);
    check("addi_valid", out_valid, 1);
    check("addi_imm", out_imm, 32'hFFFF_FFFF);
    check("addi_fmt", out_fmt, 1);
    check("addi_illegal", out_illegal, 0);
    check("addi_pc", out_pc, 32'h0000_1000);
    check("addi_imm64", out_imm64, 64'hFFFF_FFFF_FFFF_FFFF);

    issue1(32'hFE112E23, 32'h0000_1004);
    check("sw_imm", out_imm, 32'hFFFF_FFFC);
    check("sw_fmt", out_fmt, 2);

    issue1(32'hFF9FF06F, 32'h0000_1008);
    check("jal_imm", out_imm, 32'hFFFF_FFF8);
    check("jal_fmt", out_fmt, 5);

    issue1(32'hFE000EE3, 32'h0000_100C);
    check("beq_imm", out_imm, 32'hFFFF_FFFC);
    check("beq_fmt", out_fmt, 3);

    issue1(32'h003100B3, 32'h0000_1010);
    check("add_imm", out_imm, 0);
    check("add_fmt", out_fmt, 0);
    check("add_illegal", out_illegal, 0);

    issue1(32'h123452B7, 32'h0000_1014);
    check("lui32_imm", out_imm, 32'h1234_5000);
    check("lui32_imm64", out_imm64, 64'h0000_0000_1234_5000);
    check("lui32_fmt", out_fmt, 4);

    issue1(32'h800002B7, 32'h0000_1018);
    check("lui64_imm", out_imm64, 64'hFFFF_FFFF_8000_0000);
    check("lui64_fmt", out_fmt64, 4);
    check("lui64_imm32", out_imm, 32'h8000_0000);

    issue1(32'h0000007F, 32'h0000_101C);
    check("bad_op_illegal", out_illegal, 1);
    check("bad_op_imm", out_imm, 0);
    check("bad_op_fmt", out_fmt, 6);
    check("bad_op_valid", out_valid, 1);

    issue1(32'h00000011, 32'h0000_1020);
    check("low_bits_illegal", out_illegal, 1);

    issue1(32'h00A0A073, 32'h0000_1024);
`ifdef IMM_DECODE_ZICSR_EN
    check("system_fmt", out_fmt, 7);
    check("system_imm", out_imm, 32'h0000_0001);
    check("system_illegal", out_illegal, 0);
`else
    check("system_fmt", out_fmt, 6);
    check("system_illegal", out_illegal, 1);
`endif

    step();
    check("idle_out_valid", out_valid, 0);

    // back-pressure: three back-to-back entries while downstream stalls
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h2000;
    step();
    check("bp_a_out", out_instr, 32'h00100093);
    check("bp_a_ready", in_ready, 1);
    in_instr = 32'h00200093; in_pc = 32'h2004;
    step();
    check("bp_b_ready", in_ready, 0);
    check("bp_b_hold", out_instr, 32'h00100093);
    in_instr = 32'h00300093; in_pc = 32'h2008;
    step();
    check("bp_c_hold", out_instr, 32'h00100093);
    check("bp_c_hold_imm", out_imm, 1);
    check("bp_c_ready", in_ready, 0);
    out_ready = 1'b1;
    step();
    $display("txn drain out_instr=%h imm=%h", out_instr, out_imm);
    check("bp_drain_b", out_instr, 32'h00200093);
    check("bp_drain_b_imm", out_imm, 2);
    check("bp_drain_b_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    $display("txn drain out_instr=%h imm=%h", out_instr, out_imm);
    check("bp_drain_c", out_instr, 32'h00300093);
    check("bp_drain_c_pc", out_pc, 32'h2008);
    check("bp_drain_c_valid", out_valid, 1);
    step();
    check("bp_empty", out_valid, 0);

    // flush with both slots full and in_valid high
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00400093;
    step();
    in_instr = 32'h00500093;
    step();
    in_instr = 32'h00600093; flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_out_valid", out_valid, 0);
    check("flush_in_ready", in_ready, 1);
    issue1(32'h00700093, 32'h3000);
    check("post_flush_valid", out_valid, 1);
    check("post_flush_instr", out_instr, 32'h00700093);
    step();

    // flush dominates a simultaneous accept into an empty stage
    in_valid = 1'b1; in_instr = 32'h00800093; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_drop", out_valid, 0);

    // reset in the middle of a stall
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00900093;
    step();
    in_instr = 32'h00A00093;
    step();
    reset = 1'b1; in_valid = 1'b0;
    step();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_instr", out_instr, 0);
    check("rst_mid_fmt", out_fmt, 6);
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    check("rst_mid_no_ghost", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
